read_master_sequencer: RTL and testbench

- Sequences one Avalon-MM burst read master for a single word-aligned descriptor: start address plus byte length.
- Issues bursts sized by alignment, remaining length and maximum burst; holds each command through waitrequest; tracks outstanding read words against downstream FIFO space; signals completion.
- Sits between the descriptor/control register block and the read datapath FIFO of each OpenCL memory-read engine.

---
 rtl/read_master_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_read_master_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/read_master_sequencer.sv
// -----------------------------------------------------------------------------
// read_master_sequencer
//
// Sequences one Avalon-MM burst read master over a single word-aligned
// descriptor (start address + byte length). Burst sizes follow address
// alignment, the words still to issue and the maximum burst. A command is held
// through waitrequest. Issued-but-unreturned words are tracked so that the
// downstream FIFO can never overflow. A one-cycle done pulse ends the transfer.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   go                      start pulse, only looked at while idle
//   start_address           byte address (low WORD_SIZE_LOG2 bits ignored)
//   transfer_length         byte count   (low WORD_SIZE_LOG2 bits ignored)
//   stop                    level: stop issuing, drain what is outstanding
//   busy                    transfer in progress
//   done                    one-cycle completion pulse
//   stopped                 qualifies done: the transfer ended through stop
//   master_address          Avalon word-aligned byte address
//   master_read             Avalon read request
//   master_burstcount       Avalon burst length in words
//   master_waitrequest      Avalon waitrequest
//   master_readdatavalid    one returned word
//   fifo_used               downstream FIFO occupancy in words
// -----------------------------------------------------------------------------
module read_master_sequencer #(
    parameter int ADDRESS_WIDTH          = 32,
    parameter int LENGTH_WIDTH           = 32,
    parameter int WORD_SIZE_LOG2         = 2,
    parameter int BURST_COUNT_WIDTH      = 3,
    parameter int BURST_WRAPPING_SUPPORT = 1,
    parameter int FIFO_DEPTH_LOG2        = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic [ADDRESS_WIDTH-1:0]     start_address,
    input  logic [LENGTH_WIDTH-1:0]      transfer_length,
    input  logic                         stop,
    output logic                         busy,
    output logic                         done,
    output logic                         stopped,
    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_read,
    output logic [BURST_COUNT_WIDTH-1:0] master_burstcount,
    input  logic                         master_waitrequest,
    input  logic                         master_readdatavalid,
    input  logic [FIFO_DEPTH_LOG2:0]     fifo_used
);

    localparam int MAX_BURST = 1 << (BURST_COUNT_WIDTH - 1);
    localparam int PW        = FIFO_DEPTH_LOG2 + 1;
    // Room for the sum of two PW-bit values plus a burst without wrapping.
    localparam int GW        = FIFO_DEPTH_LOG2 + 3;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
        ~ADDRESS_WIDTH'((1 << WORD_SIZE_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LENGTH_WIDTH-1:0]  rem_q, rem_d;
    logic [PW-1:0]            pend_q, pend_d;
    logic                     held_q, held_d;
    logic                     stopped_q, stopped_d;

    logic [BURST_COUNT_WIDTH-1:0] burst;
    logic                         misaligned;
    logic                         gate;
    logic                         accept;
    logic                         rdv_dec;

    // With wrapping support, single-word bursts walk the address up to the
    // next MAX_BURST boundary so that no burst crosses a wrap boundary.
    generate
        if (BURST_WRAPPING_SUPPORT != 0 && BURST_COUNT_WIDTH > 1) begin : g_wrap
            assign misaligned =
                |addr_q[BURST_COUNT_WIDTH-2+WORD_SIZE_LOG2:WORD_SIZE_LOG2];
        end else begin : g_nowrap
            assign misaligned = 1'b0;
        end
    endgenerate

    always_comb begin
        if (misaligned) begin
            burst = BURST_COUNT_WIDTH'(1);
        end else if (rem_q >= LENGTH_WIDTH'(MAX_BURST)) begin
            burst = BURST_COUNT_WIDTH'(MAX_BURST);
        end else begin
            burst = rem_q[BURST_COUNT_WIDTH-1:0];
        end
    end

    // Only issue when every word of this burst already has a FIFO slot.
    assign gate = (GW'(fifo_used) + GW'(pend_q) + GW'(burst))
                  <= GW'(1 << FIFO_DEPTH_LOG2);

    // A held command bypasses gate and stop so the bus sees a stable request.
    assign master_read = (state_q == S_ISSUE) && (held_q || (gate && !stop));
    assign accept      = master_read && !master_waitrequest;
    // Returns after a reset belong to an abandoned transfer; never underflow.
    assign rdv_dec     = master_readdatavalid && (state_q != S_IDLE) && (pend_q != '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            pend_q    <= '0;
            held_q    <= 1'b0;
            stopped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            pend_q    <= pend_d;
            held_q    <= held_d;
            stopped_q <= stopped_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        stopped_d = stopped_q;
        held_d    = master_read && master_waitrequest;

        pend_d = pend_q;
        if (accept) begin
            pend_d = pend_d + PW'(burst);
        end
        if (rdv_dec) begin
            pend_d = pend_d - PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    addr_d    = start_address & ADDR_MASK;
                    rem_d     = transfer_length >> WORD_SIZE_LOG2;
                    stopped_d = 1'b0;
                    state_d   = ((transfer_length >> WORD_SIZE_LOG2) != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    addr_d = addr_q + (ADDRESS_WIDTH'(burst) << WORD_SIZE_LOG2);
                    rem_d  = rem_q - LENGTH_WIDTH'(burst);
                    if (rem_q == LENGTH_WIDTH'(burst)) begin
                        state_d = S_DRAIN;
                    end
                end else if (!held_q && stop) begin
                    state_d   = S_DRAIN;
                    stopped_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (pend_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy              = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done              = (state_q == S_DONE);
        stopped           = (state_q == S_DONE) && stopped_q;
        master_address    = addr_q;
        master_burstcount = master_read ? burst : '0;
    end

endmodule

// File: tb/tb_read_master_sequencer.sv
module tb_read_master_sequencer;
    localparam int AW   = 32;
    localparam int LW   = 32;
    localparam int WS   = 2;
    localparam int BCW  = 3;
    localparam int WRAP = 1;
    localparam int F    = 3;
    localparam int MAXB = 1 << (BCW - 1);
    localparam int CAP  = 1 << F;

    logic           clk = 1'b0;
    logic           reset;
    logic           go;
    logic [AW-1:0]  start_address;
    logic [LW-1:0]  transfer_length;
    logic           stop;
    logic           busy;
    logic           done;
    logic           stopped;
    logic [AW-1:0]  master_address;
    logic           master_read;
    logic [BCW-1:0] master_burstcount;
    logic           master_waitrequest;
    logic           master_readdatavalid;
    logic [F:0]     fifo_used;

    int checks = 0;
    int errors = 0;

    // Reference command list and return-channel model
    logic [31:0] exp_a[$];
    int          exp_b[$];
    int          rq[$];
    int          cyc_n = 0;
    int          issued, returned, last_ret;
    int          wr_mode, hold_left, fu_mode;

    always #5 clk = ~clk;

    read_master_sequencer #(
        .ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW), .WORD_SIZE_LOG2(WS),
        .BURST_COUNT_WIDTH(BCW), .BURST_WRAPPING_SUPPORT(WRAP), .FIFO_DEPTH_LOG2(F)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .start_address(start_address),
        .transfer_length(transfer_length), .stop(stop), .busy(busy), .done(done),
        .stopped(stopped), .master_address(master_address), .master_read(master_read),
        .master_burstcount(master_burstcount), .master_waitrequest(master_waitrequest),
        .master_readdatavalid(master_readdatavalid), .fifo_used(fifo_used)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Burst list derived directly from the alignment / length / max-burst rules.
    task automatic build(input logic [31:0] a, input logic [31:0] len);
        logic [31:0] addr;
        int rem, b;
        exp_a.delete();
        exp_b.delete();
        addr = a & 32'hFFFF_FFFC;
        rem  = int'(len >> WS);
        while (rem > 0) begin
            if (WRAP != 0 && ((addr >> WS) % MAXB) != 0) b = 1;
            else b = (rem < MAXB) ? rem : MAXB;
            exp_a.push_back(addr);
            exp_b.push_back(b);
            addr = addr + 32'(b * 4);
            rem  = rem - b;
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_stopped"}, stopped, 0);
        chk({tag, "_read"}, master_read, 0);
        chk({tag, "_bc"}, master_burstcount, 0);
    endtask

    task automatic run_xfer(input logic [31:0] a, input logic [31:0] len,
                            input int stop_after, input int abort_after, input int exp_hold);
        int n, acc, held_cnt, last_rdv_k, t;
        bit prev_held, fin, exp_rd, exp_stopped;
        logic [31:0] pa;
        logic [BCW-1:0] pb;
        build(a, len);
        n = exp_a.size();
        exp_stopped = (stop_after >= 0) && (stop_after < n);
        acc = 0; held_cnt = 0; prev_held = 0; fin = 0; last_rdv_k = 0;
        pa = '0; pb = '0;
        issued = 0; returned = 0; last_ret = 0;
        rq.delete();
        @(negedge clk);
        cyc_n++;
        start_address = a; transfer_length = len; go = 1'b1;
        stop = (stop_after == 0);
        master_readdatavalid = 1'b0; master_waitrequest = 1'b0;
        for (int k = 0; k < 800 && !fin; k++) begin
            @(negedge clk);
            cyc_n++;
            go = 1'b0;
            stop = (stop_after >= 0) && (acc >= stop_after);
            case (wr_mode)
                1:       master_waitrequest = (hold_left > 0);
                2:       master_waitrequest = ($urandom_range(0, 2) == 0);
                default: master_waitrequest = 1'b0;
            endcase
            case (fu_mode)
                1:       fifo_used = (k < 3) ? 4'd6 : (k < 5) ? 4'd5 : 4'd4;
                2:       fifo_used = 4'($urandom_range(0, CAP));
                default: fifo_used = '0;
            endcase
            master_readdatavalid = (rq.size() > 0) && (rq[0] <= cyc_n);
            #1;
            chk("busy_vs_done", busy, !done);
            if (k == 0) chk("first_cycle_done", done, n == 0);
            if (prev_held) begin
                chk("hold_read", master_read, 1);
                chk("hold_addr", master_address, pa);
                chk("hold_bc", master_burstcount, pb);
            end else if (busy) begin
                exp_rd = (acc < n) && !stop &&
                         (int'(fifo_used) + (issued - returned) + exp_b[acc] <= CAP);
                chk("read_gate", master_read, exp_rd);
            end else begin
                chk("read_not_busy", master_read, 0);
            end
            if (master_read && acc < n) begin
                chk("cmd_addr", master_address, exp_a[acc]);
                chk("cmd_bc", master_burstcount, exp_b[acc]);
            end
            if (master_read && !master_waitrequest) begin
                acc++;
                issued += int'(master_burstcount);
                for (int j = 0; j < int'(master_burstcount); j++) begin
                    t = (cyc_n + 3 > last_ret + 1) ? cyc_n + 3 : last_ret + 1;
                    rq.push_back(t);
                    last_ret = t;
                end
            end
            prev_held = master_read && master_waitrequest;
            if (prev_held) begin
                pa = master_address;
                pb = master_burstcount;
                held_cnt++;
                if (wr_mode == 1) hold_left--;
            end
            if (master_readdatavalid) begin
                void'(rq.pop_front());
                returned++;
                last_rdv_k = k;
            end
            if (done) begin
                fin = 1;
                chk("done_stopped", stopped, exp_stopped);
                chk("n_cmds", acc, exp_stopped ? stop_after : n);
                chk("all_returned", returned, issued);
                if (issued > 0) chk("done_latency_ok", (k - last_rdv_k) <= 2, 1);
                if (exp_hold >= 0) chk("hold_cycles", held_cnt, exp_hold);
            end
            if (abort_after >= 0 && acc >= abort_after) fin = 1;
        end
        if (!fin) chk("timeout", 0, 1);
        if (abort_after < 0) begin
            @(negedge clk);
            cyc_n++;
            master_readdatavalid = 1'b0; master_waitrequest = 1'b0; stop = 1'b0;
            #1;
            chk("done_one_pulse", done, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; stop = 1'b0; start_address = '0; transfer_length = '0;
        master_waitrequest = 1'b0; master_readdatavalid = 1'b0; fifo_used = '0;
        wr_mode = 0; hold_left = 0; fu_mode = 0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        chk("reset_addr", master_address, 0);
        @(negedge clk);
        reset = 1'b0;

        // Aligned: bursts 4,4,2 at 0x100/0x110/0x120
        run_xfer(32'h100, 32'd40, -1, -1, -1);
        // Unaligned start: 1,1,1,4,1
        run_xfer(32'h104, 32'd32, -1, -1, -1);
        // Waitrequest hold for 5 cycles on the first command
        wr_mode = 1; hold_left = 5;
        run_xfer(32'h40, 32'd16, -1, -1, 5);
        wr_mode = 0;
        // FIFO backpressure: read stays low until fifo_used reaches 4
        fu_mode = 1;
        run_xfer(32'h0, 32'd16, -1, -1, -1);
        fu_mode = 0;
        // Stop after the first accept
        run_xfer(32'h300, 32'd40, 1, -1, -1);
        // Zero length (3 bytes rounds to no words)
        run_xfer(32'h500, 32'd3, -1, -1, -1);
        // Address wrap across 2^32
        run_xfer(32'hFFFF_FFF8, 32'd16, -1, -1, -1);

        // Reset with four words outstanding
        run_xfer(32'h200, 32'd64, -1, 1, -1);
        @(negedge clk);
        master_readdatavalid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_quiet("midreset");
        chk("midreset_addr", master_address, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            master_readdatavalid = 1'b1;
            #1;
            chk("stray_rdv_busy", busy, 0);
            chk("stray_rdv_read", master_read, 0);
        end
        @(negedge clk);
        master_readdatavalid = 1'b0;
        run_xfer(32'h600, 32'd48, -1, -1, -1);

        // Randomised transfers with random waitrequest, FIFO level and stop
        wr_mode = 2; fu_mode = 2;
        for (int i = 0; i < 12; i++) begin
            run_xfer($urandom, 32'($urandom_range(0, 100)),
                     int'($urandom_range(0, 5)) - 1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
